// File: rtl/timer_wb_regs_if.sv
// Wishbone classic bus bundle for the timer register block.
// Signal names keep the responder's point of view (i_ = into the registers).
interface timer_wb_regs_if #(
  parameter int DW = 32
);
  logic          i_wb_cyc;
  logic          i_wb_stb;
  logic          i_wb_we;
  logic [1:0]    i_wb_adr;
  logic [DW-1:0] i_wb_dat;
  logic [DW-1:0] o_wb_dat;
  logic          o_wb_ack;

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_dat,
    output o_wb_dat, o_wb_ack
  );

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_dat,
    input  o_wb_dat, o_wb_ack
  );
endinterface

// File: rtl/timer_wb_regs.sv
// Register front end of timer_core: config registers, sticky irq status,
// saturating event counter and the active-low irq-clear pulse to the core.
module timer_wb_regs #(
  parameter int          DW         = 32,
  parameter logic [15:0] PERIOD_RST = 16'hFFFF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  timer_wb_regs_if.slave       wb,
  output logic                 o_timer_core_en,
  output logic                 o_cont,
  output logic [15:0]          o_period,
  output logic                 o_irq_clear,
  input  logic                 i_core_irq,
  output logic                 o_irq
);

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PERIOD = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_EVCNT  = 2'd3;

  logic          ack_q, ack_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          en_q, en_d;
  logic          cont_q, cont_d;
  logic          irq_en_q, irq_en_d;
  logic [15:0]   period_q, period_d;
  logic          pending_q, pending_d;
  logic [7:0]    evcnt_q, evcnt_d;
  logic          irq_d_q, irq_d_d;
  logic          clr_n_q, clr_n_d;

  logic          req, wr, rd, irq_edge, w1c;
  logic [DW-1:0] rdat;

  // Only the low half-word of write data is ever stored.
  logic unused_wdat;
  assign unused_wdat = ^wb.i_wb_dat[DW-1:16];

  // Next-state: bus decode, register updates, event capture and clear pulse.
  always_comb begin
    req      = wb.i_wb_cyc & wb.i_wb_stb & ~ack_q;
    wr       = req & wb.i_wb_we;
    rd       = req & ~wb.i_wb_we;
    irq_edge = i_core_irq & ~irq_d_q;
    w1c      = wr & (wb.i_wb_adr == A_STATUS) & wb.i_wb_dat[0];

    rdat = '0;
    case (wb.i_wb_adr)
      A_CTRL:   rdat[2:0]  = {irq_en_q, cont_q, en_q};
      A_PERIOD: rdat[15:0] = period_q;
      A_STATUS: rdat[1:0]  = {i_core_irq, pending_q};
      default:  rdat[7:0]  = evcnt_q;
    endcase

    ack_d    = req;
    dat_d    = rd ? rdat : '0;
    en_d     = en_q;
    cont_d   = cont_q;
    irq_en_d = irq_en_q;
    period_d = period_q;
    irq_d_d  = i_core_irq;
    clr_n_d  = ~w1c;

    if (wr && wb.i_wb_adr == A_CTRL) begin
      en_d     = wb.i_wb_dat[0];
      cont_d   = wb.i_wb_dat[1];
      irq_en_d = wb.i_wb_dat[2];
    end
    if (wr && wb.i_wb_adr == A_PERIOD)
      period_d = wb.i_wb_dat[15:0];

    // Clear first so a coincident edge re-sets pending.
    pending_d = pending_q;
    if (w1c)      pending_d = 1'b0;
    if (irq_edge) pending_d = 1'b1;

    // Increment first so a coincident EVCNT write overrides it.
    evcnt_d = evcnt_q;
    if (irq_edge && evcnt_q != 8'hFF) evcnt_d = evcnt_q + 8'd1;
    if (wr && wb.i_wb_adr == A_EVCNT)  evcnt_d = 8'd0;
  end

  // State registers; async reset cancels any ack or clear pulse in flight.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      en_q      <= 1'b0;
      cont_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      period_q  <= PERIOD_RST;
      pending_q <= 1'b0;
      evcnt_q   <= 8'd0;
      irq_d_q   <= 1'b0;
      clr_n_q   <= 1'b1;
    end else begin
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      en_q      <= en_d;
      cont_q    <= cont_d;
      irq_en_q  <= irq_en_d;
      period_q  <= period_d;
      pending_q <= pending_d;
      evcnt_q   <= evcnt_d;
      irq_d_q   <= irq_d_d;
      clr_n_q   <= clr_n_d;
    end
  end

  assign wb.o_wb_ack     = ack_q;
  assign wb.o_wb_dat     = dat_q;
  assign o_timer_core_en = en_q;
  assign o_cont          = cont_q;
  assign o_period        = period_q;
  assign o_irq_clear     = clr_n_q;
  assign o_irq           = pending_q & irq_en_q;

endmodule

// File: tb/tb_timer_wb_regs.sv
// Bench for timer_wb_regs: vector table, hand sequences for corner cases and
// randomized traffic checked every cycle against a register-level model.
module tb_timer_wb_regs;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        o_timer_core_en, o_cont, o_irq_clear, o_irq;
  logic [15:0] o_period;
  logic        i_core_irq = 1'b0;

  timer_wb_regs_if #(.DW(32)) wb ();

  timer_wb_regs #(.DW(32), .PERIOD_RST(16'hFFFF)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .wb             (wb),
    .o_timer_core_en(o_timer_core_en),
    .o_cont         (o_cont),
    .o_period       (o_period),
    .o_irq_clear    (o_irq_clear),
    .i_core_irq     (i_core_irq),
    .o_irq          (o_irq)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents as plain values, updated per bus rules.
  bit          m_en, m_cont, m_irqen, m_pend, m_prev, m_ack, m_clr_n;
  int          m_period, m_ev;
  logic [31:0] m_rdat;
  bit          chk_en = 0;

  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      m_en <= 0; m_cont <= 0; m_irqen <= 0; m_pend <= 0; m_prev <= 0;
      m_ack <= 0; m_clr_n <= 1; m_period <= 'hFFFF; m_ev <= 0; m_rdat <= 0;
    end else begin
      automatic bit req = wb.i_wb_cyc && wb.i_wb_stb && !m_ack;
      automatic bit wr  = req && wb.i_wb_we;
      automatic bit ev  = i_core_irq && !m_prev;
      automatic int a   = int'(wb.i_wb_adr);
      automatic int wd  = int'(wb.i_wb_dat);
      automatic bit clr = wr && a == 2 && wd[0];
      automatic int rv;
      automatic bit np;
      automatic int ne;
      case (a)
        0:       rv = m_irqen * 4 + m_cont * 2 + m_en;
        1:       rv = m_period;
        2:       rv = i_core_irq * 2 + m_pend;
        default: rv = m_ev;
      endcase
      np = ev ? 1'b1 : (clr ? 1'b0 : m_pend);
      ne = (wr && a == 3) ? 0 : (ev ? ((m_ev < 255) ? m_ev + 1 : 255) : m_ev);
      m_ack   <= req;
      m_rdat  <= (req && !wb.i_wb_we) ? rv : 0;
      m_prev  <= i_core_irq;
      m_pend  <= np;
      m_ev    <= ne;
      m_clr_n <= !clr;
      if (wr && a == 0) begin
        m_en <= wd[0]; m_cont <= wd[1]; m_irqen <= wd[2];
      end
      if (wr && a == 1) m_period <= wd & 'hFFFF;
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("m_ack",    {31'b0, wb.o_wb_ack},      {31'b0, m_ack});
      chk("m_dat",    wb.o_wb_dat,               m_rdat);
      chk("m_period", {16'b0, o_period},         m_period);
      chk("m_en",     {31'b0, o_timer_core_en},  {31'b0, m_en});
      chk("m_cont",   {31'b0, o_cont},           {31'b0, m_cont});
      chk("m_clr",    {31'b0, o_irq_clear},      {31'b0, m_clr_n});
      chk("m_irq",    {31'b0, o_irq},            {31'b0, m_pend & m_irqen});
    end
  end

  bit   irq_on_req = 0;
  logic t_clr;

  // One bus access; stb held through the ack cycle to prove ack lasts one cycle.
  task automatic bus(input bit we, input logic [1:0] adr, input logic [31:0] wdat,
                     output logic [31:0] rdat);
    @(negedge i_clk);
    wb.i_wb_cyc = 1; wb.i_wb_stb = 1; wb.i_wb_we = we;
    wb.i_wb_adr = adr; wb.i_wb_dat = wdat;
    if (irq_on_req) i_core_irq = 1;
    @(posedge i_clk); #1;
    chk("ack_rise", {31'b0, wb.o_wb_ack}, 32'd1);
    rdat  = wb.o_wb_dat;
    t_clr = o_irq_clear;
    @(posedge i_clk); #1;
    chk("ack_one_cycle", {31'b0, wb.o_wb_ack}, 32'd0);
    @(negedge i_clk);
    wb.i_wb_cyc = 0; wb.i_wb_stb = 0; wb.i_wb_we = 0;
  endtask

  task automatic wr(input logic [1:0] adr, input logic [31:0] d);
    logic [31:0] dummy;
    bus(1'b1, adr, d, dummy);
  endtask

  task automatic rd(input string name, input logic [1:0] adr, input logic [31:0] exp);
    logic [31:0] r;
    bus(1'b0, adr, 32'h0, r);
    chk(name, r, exp);
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  adr;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] r;
    wb.i_wb_cyc = 0; wb.i_wb_stb = 0; wb.i_wb_we = 0;
    wb.i_wb_adr = 0; wb.i_wb_dat = 0;

    // Reset state while held.
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ack",    {31'b0, wb.o_wb_ack}, 0);
    chk("rst_dat",    wb.o_wb_dat, 0);
    chk("rst_period", {16'b0, o_period}, 32'hFFFF);
    chk("rst_clr",    {31'b0, o_irq_clear}, 1);
    chk("rst_en",     {30'b0, o_timer_core_en, o_cont}, 0);
    chk("rst_irq",    {31'b0, o_irq}, 0);
    @(negedge i_clk);
    i_rst  = 1;
    chk_en = 1;

    // Vector table: reset read-back, config writes, unused bits read 0.
    vecs = '{
      '{0, 2'd0, 32'h0,        32'h0},
      '{0, 2'd1, 32'h0,        32'hFFFF},
      '{0, 2'd2, 32'h0,        32'h0},
      '{0, 2'd3, 32'h0,        32'h0},
      '{1, 2'd1, 32'hABCD1234, 32'h0},
      '{0, 2'd1, 32'h0,        32'h1234},
      '{1, 2'd0, 32'hFFFFFFF8, 32'h0},
      '{0, 2'd0, 32'h0,        32'h0},
      '{1, 2'd1, 32'h5,        32'h0},
      '{1, 2'd0, 32'h5,        32'h0},
      '{0, 2'd1, 32'h0,        32'h5},
      '{0, 2'd0, 32'h0,        32'h5}
    };
    foreach (vecs[i]) begin
      bus(vecs[i].we, vecs[i].adr, vecs[i].wdat, r);
      if (!vecs[i].we) chk($sformatf("vec%0d", i), r, vecs[i].exp);
    end

    // One-shot config and an irq from the core.
    chk("cfg_period", {16'b0, o_period}, 32'd5);
    chk("cfg_en",     {30'b0, o_timer_core_en, o_cont}, 32'h2);
    @(negedge i_clk); i_core_irq = 1;
    repeat (2) @(negedge i_clk);
    chk("irq_set", {31'b0, o_irq}, 1);
    rd("status_3", 2'd2, 32'h3);
    rd("evcnt_1",  2'd3, 32'h1);
    @(negedge i_clk); i_core_irq = 0;

    // Clear: pulse for W1C, none for a zero write.
    wr(2'd2, 32'h1);
    chk("clr_pulse", {31'b0, t_clr}, 0);
    chk("clr_back",  {31'b0, o_irq_clear}, 1);
    chk("clr_irq",   {31'b0, o_irq}, 0);
    wr(2'd2, 32'h0);
    chk("no_pulse",  {31'b0, t_clr}, 1);
    rd("status_0", 2'd2, 32'h0);

    // Continuous mode, three events, then mask.
    wr(2'd3, 32'h0);
    wr(2'd0, 32'h7);
    wr(2'd1, 32'h7);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk); i_core_irq = 1;
      @(negedge i_clk); i_core_irq = 0;
      @(negedge i_clk);
    end
    rd("evcnt_3", 2'd3, 32'h3);
    chk("cont_irq", {30'b0, o_irq, o_cont}, 32'h3);
    wr(2'd0, 32'h3);
    chk("masked_irq", {31'b0, o_irq}, 0);
    rd("masked_pend", 2'd2, 32'h1);

    // W1C on the same edge as a rising core irq: set wins, pulse still issued.
    irq_on_req = 1;
    wr(2'd2, 32'h1);
    irq_on_req = 0;
    chk("race_pulse", {31'b0, t_clr}, 0);
    rd("race_status", 2'd2, 32'h3);
    rd("race_evcnt",  2'd3, 32'h4);
    @(negedge i_clk); i_core_irq = 0;

    // Saturation at 255, then write clears.
    for (int i = 0; i < 300; i++) begin
      @(negedge i_clk); i_core_irq = 1;
      @(negedge i_clk); i_core_irq = 0;
    end
    rd("evcnt_sat", 2'd3, 32'hFF);
    wr(2'd3, 32'hDEAD);
    rd("evcnt_clr", 2'd3, 32'h0);

    // Async reset in the middle of a write, before its ack edge.
    wr(2'd1, 32'h1234);
    wr(2'd0, 32'h7);
    @(negedge i_clk);
    wb.i_wb_cyc = 1; wb.i_wb_stb = 1; wb.i_wb_we = 1;
    wb.i_wb_adr = 2'd1; wb.i_wb_dat = 32'h55;
    #2 i_rst = 0;
    #1;
    chk("arst_ack",    {31'b0, wb.o_wb_ack}, 0);
    chk("arst_period", {16'b0, o_period}, 32'hFFFF);
    chk("arst_ctrl",   {29'b0, o_timer_core_en, o_cont, o_irq}, 0);
    chk("arst_clr",    {31'b0, o_irq_clear}, 1);
    @(posedge i_clk); #1;
    chk("arst_hold",   {16'b0, o_period}, 32'hFFFF);
    @(negedge i_clk);
    wb.i_wb_cyc = 0; wb.i_wb_stb = 0; wb.i_wb_we = 0;
    i_rst = 1;
    rd("arst_rd_per",  2'd1, 32'hFFFF);
    rd("arst_rd_ctrl", 2'd0, 32'h0);

    // Randomized traffic, checked against the model every cycle.
    for (int i = 0; i < 200; i++) begin
      automatic bit          we = 1'($urandom_range(0, 1));
      automatic logic [1:0]  a  = 2'($urandom_range(0, 3));
      automatic logic [31:0] d  = $urandom;
      @(negedge i_clk);
      i_core_irq = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) @(negedge i_clk);
      bus(we, a, d, r);
    end

    repeat (2) @(negedge i_clk);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
